plb_access_scheduler: RTL and testbench
=======================================

// Module: plb_access_scheduler
// PURPOSE
//  Front-end scheduler for the PosMap/PLB lookup unit. Shares its single command port between two requesters
//  (0: ORAM frontend update/read, 1: recursion/refill engine) by round-robin arbitration.
//  Issues one command at a time, streams refill leaves for CacheRefill, and routes the unit's result back to the granted requester.
//  Sits between the frontend request logic and the PosMap/PLB unit.
// PARAMETERS
//  ORAMU        32  program/posmap address width
//  ORAML        20  leaf label width
//  LeafWidth    32  width of one stored leaf entry (valid bit + label, padded)
//  LeafInBlock  16  leaves per PLB line = refill words per CacheRefill (power of 2, >=2)
//  StatWidth    32  width of hit/miss counters
// PORTS
//  Clock          in   1            system clock, rising edge
//  Reset          in   1            synchronous, active-high
//  ReqValid       in   2            per-requester command valid
//  ReqReady       out  2            per-requester accept (one-hot, one cycle)
//  ReqCmd         in   2*2          per-requester cmd {r1,r0}: 00 update, 01 read, 10 refill, 11 init_refill
//  ReqAddr        in   2*ORAMU      per-requester address {r1,r0}
//  RespValid      out  2            result valid toward granted requester (one-hot)
//  RespReady      in   2            per-requester result accept
//  RespHit/RespUnInit/RespEvict out 1   result flags
//  RespOldLeaf, RespNewLeaf out ORAML   result leaves
//  RespAddr       out  ORAMU        evicted/result address
//  RefillValid    in   1            refill leaf word valid
//  RefillReady    out  1            refill leaf word accepted
//  RefillData     in   LeafWidth    refill leaf word
//  PLBCmdValid    out  1; PLBCmdReady in 1; PLBCmd out 2; PLBAddr out ORAMU   unit command port
//  PLBDInValid    out  1; PLBDIn out LeafWidth; PLBRefillDataReady in 1       unit refill data port
//  PLBValid, PLBHit, PLBUnInit, PLBEvict in 1; PLBOldLeaf, PLBNewLeaf in ORAML; PLBAddrOut in ORAMU; PLBOutReady out 1
//  StatHits, StatMisses out StatWidth   hit/miss counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM->IDLE; ReqReady, RespValid, RefillReady, PLBCmdValid, PLBDInValid, PLBOutReady = 0; RR pointer -> requester 0 wins first; counters 0.
//  Reset mid-operation aborts any command/refill; no response is delivered afterwards.
//  States: IDLE -> ISSUE -> (REFILL) -> WAIT -> IDLE.
//  IDLE: if any ReqValid, grant: single requester wins; both -> the one NOT granted last. ReqReady[g]=1 that cycle,
//   cmd/addr latched into regs; next state ISSUE. Latency: accept at cycle t, PLBCmdValid at t+1.
//  ISSUE: PLBCmdValid=1, PLBCmd/PLBAddr = latched values, held stable until PLBCmdReady.
//   On handshake: cmd 10 -> REFILL (word counter=0); else -> WAIT.
//  REFILL: PLBDIn=RefillData; PLBDInValid = RefillValid && PLBRefillDataReady; RefillReady = PLBRefillDataReady.
//   Each RefillValid&&RefillReady transfer increments counter (log2(LeafInBlock) bits);
//   transfer with counter==LeafInBlock-1 -> WAIT. Words offered outside REFILL are not accepted (RefillReady=0).
//  WAIT: RespValid[g]=PLBValid; Resp* fields = PLB* pass-through; PLBOutReady = RespReady[g].
//   On PLBValid&&RespReady[g] -> IDLE, RR pointer := g. PLBOutReady=0 in every other state (unit holds its result).
//  Requesters must keep ReqValid/cmd/addr stable until ReqReady. The non-granted ReqValid waits with no starvation:
//   a waiting requester is served before the other requester is served again.
//  No new command is issued until the previous response completes (one outstanding command maximum).
//  RespValid is never asserted to the non-granted requester; RespReady of the non-granted requester is ignored.
// CONFIGURATION
//  PLB_STATS_EN defined: on each WAIT completion of cmd 00/01, StatHits+=1 if PLBHit else StatMisses+=1;
//   refill/init_refill are not counted; counters saturate at all-ones; cleared by Reset.
//  PLB_STATS_EN undefined: StatHits=StatMisses=0 constant; no counter logic.
// TESTING
//  Single req0 read addr 0x40, PLB hits after 2 cycles -> ReqReady[0] at t, PLBCmdValid at t+1, RespValid[0]=1, RespHit=1.
//  ReqValid=2'b11 held for 4 commands, both read -> grant order 0,1,0,1; never two consecutive grants to one requester.
//  req1 refill addr 0x100, LeafInBlock=16, RefillValid toggling -> exactly 16 PLBDInValid pulses, then WAIT; 17th word not accepted.
//  req1 init_refill addr 0x200 -> no REFILL state, RefillReady stays 0, response routed to RespValid[1].
//  RespReady[0] held 0 for 10 cycles with PLBValid=1 -> PLBOutReady=0, no new ReqReady, state WAIT until RespReady[0]=1.
//  Reset asserted during REFILL word 5 -> next cycle all outputs 0, IDLE; PLB_STATS_EN: 3 hits + 1 miss -> StatHits=3, StatMisses=1.

Source files
------------

// File: rtl/plb_access_scheduler_if.sv
// Bundle of requester, refill and PosMap/PLB unit signals seen by plb_access_scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding logic's view.
interface plb_access_scheduler_if #(
    parameter int ORAMU     = 32,
    parameter int ORAML     = 20,
    parameter int LeafWidth = 32
);
    logic [1:0]           ReqValid;
    logic [1:0]           ReqReady;
    logic [3:0]           ReqCmd;
    logic [2*ORAMU-1:0]   ReqAddr;
    logic [1:0]           RespValid;
    logic [1:0]           RespReady;
    logic                 RespHit;
    logic                 RespUnInit;
    logic                 RespEvict;
    logic [ORAML-1:0]     RespOldLeaf;
    logic [ORAML-1:0]     RespNewLeaf;
    logic [ORAMU-1:0]     RespAddr;
    logic                 RefillValid;
    logic                 RefillReady;
    logic [LeafWidth-1:0] RefillData;
    logic                 PLBCmdValid;
    logic                 PLBCmdReady;
    logic [1:0]           PLBCmd;
    logic [ORAMU-1:0]     PLBAddr;
    logic                 PLBDInValid;
    logic [LeafWidth-1:0] PLBDIn;
    logic                 PLBRefillDataReady;
    logic                 PLBValid;
    logic                 PLBHit;
    logic                 PLBUnInit;
    logic                 PLBEvict;
    logic [ORAML-1:0]     PLBOldLeaf;
    logic [ORAML-1:0]     PLBNewLeaf;
    logic [ORAMU-1:0]     PLBAddrOut;
    logic                 PLBOutReady;

    modport slave (
        input  ReqValid, ReqCmd, ReqAddr, RespReady, RefillValid, RefillData,
               PLBCmdReady, PLBRefillDataReady, PLBValid, PLBHit, PLBUnInit, PLBEvict,
               PLBOldLeaf, PLBNewLeaf, PLBAddrOut,
        output ReqReady, RespValid, RespHit, RespUnInit, RespEvict, RespOldLeaf, RespNewLeaf,
               RespAddr, RefillReady, PLBCmdValid, PLBCmd, PLBAddr, PLBDInValid, PLBDIn, PLBOutReady
    );

    modport master (
        output ReqValid, ReqCmd, ReqAddr, RespReady, RefillValid, RefillData,
               PLBCmdReady, PLBRefillDataReady, PLBValid, PLBHit, PLBUnInit, PLBEvict,
               PLBOldLeaf, PLBNewLeaf, PLBAddrOut,
        input  ReqReady, RespValid, RespHit, RespUnInit, RespEvict, RespOldLeaf, RespNewLeaf,
               RespAddr, RefillReady, PLBCmdValid, PLBCmd, PLBAddr, PLBDInValid, PLBDIn, PLBOutReady
    );
endinterface

// File: rtl/plb_access_scheduler.sv
// Round-robin front end sharing the PosMap/PLB command port between two requesters, one command outstanding.
// Define PLB_STATS_EN to build saturating hit/miss counters for update/read commands.
module plb_access_scheduler #(
    parameter int ORAMU       = 32,
    parameter int ORAML       = 20,
    parameter int LeafWidth   = 32,
    parameter int LeafInBlock = 16,
    parameter int StatWidth   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    plb_access_scheduler_if.slave bus,
    output logic [StatWidth-1:0] stat_hits_o,
    output logic [StatWidth-1:0] stat_misses_o
);
    localparam int CNT_W = $clog2(LeafInBlock);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REFILL, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, last_q, pick;
    logic [1:0]       cmd_q, cmd_sel;
    logic [ORAMU-1:0] addr_q, addr_sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_any, accept, refill_xfer, resp_rdy_g, resp_done;

    assign req_any     = |bus.ReqValid;
    // When both ask, the requester not served last wins; this is what prevents starvation
    assign pick        = (bus.ReqValid == 2'b11) ? ~last_q : bus.ReqValid[1];
    assign cmd_sel     = pick ? bus.ReqCmd[3:2] : bus.ReqCmd[1:0];
    assign addr_sel    = pick ? bus.ReqAddr[2*ORAMU-1:ORAMU] : bus.ReqAddr[ORAMU-1:0];
    assign accept      = (state_q == S_IDLE) && req_any;
    assign refill_xfer = (state_q == S_REFILL) && bus.RefillValid && bus.PLBRefillDataReady;
    assign resp_rdy_g  = gnt_q ? bus.RespReady[1] : bus.RespReady[0];
    assign resp_done   = (state_q == S_WAIT) && bus.PLBValid && resp_rdy_g;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept)    gnt_q  <= pick;
            if (resp_done) last_q <= gnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            cmd_q  <= cmd_sel;
            addr_q <= addr_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (req_any) state_d = S_ISSUE;
            S_ISSUE: begin
                if (bus.PLBCmdReady) begin
                    cnt_d   = '0;
                    state_d = (cmd_q == 2'b10) ? S_REFILL : S_WAIT;
                end
            end
            S_REFILL: begin
                if (refill_xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LeafInBlock - 1)) state_d = S_WAIT;
                end
            end
            S_WAIT:   if (resp_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ReqReady    = 2'b00;
        bus.PLBCmdValid = 1'b0;
        bus.RefillReady = 1'b0;
        bus.PLBDInValid = 1'b0;
        bus.RespValid   = 2'b00;
        bus.PLBOutReady = 1'b0;
        case (state_q)
            S_IDLE:   if (req_any) bus.ReqReady = pick ? 2'b10 : 2'b01;
            S_ISSUE:  bus.PLBCmdValid = 1'b1;
            S_REFILL: begin
                bus.RefillReady = bus.PLBRefillDataReady;
                bus.PLBDInValid = refill_xfer;
            end
            S_WAIT: begin
                bus.RespValid[gnt_q] = bus.PLBValid;
                bus.PLBOutReady      = resp_rdy_g;
            end
            default: ;
        endcase
    end

    assign bus.PLBCmd      = cmd_q;
    assign bus.PLBAddr     = addr_q;
    assign bus.PLBDIn      = LeafWidth'(bus.RefillData);
    assign bus.RespHit     = bus.PLBHit;
    assign bus.RespUnInit  = bus.PLBUnInit;
    assign bus.RespEvict   = bus.PLBEvict;
    assign bus.RespOldLeaf = ORAML'(bus.PLBOldLeaf);
    assign bus.RespNewLeaf = ORAML'(bus.PLBNewLeaf);
    assign bus.RespAddr    = ORAMU'(bus.PLBAddrOut);

`ifdef PLB_STATS_EN
    logic [StatWidth-1:0] hits_q, misses_q;

    function automatic logic [StatWidth-1:0] sat_inc(input logic [StatWidth-1:0] v);
        return (&v) ? v : v + StatWidth'(1);
    endfunction

    // Only update/read lookups are counted; refill traffic is not a lookup
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (resp_done && !cmd_q[1]) begin
            if (bus.PLBHit) hits_q   <= sat_inc(hits_q);
            else            misses_q <= sat_inc(misses_q);
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`else
    assign stat_hits_o   = '0;
    assign stat_misses_o = '0;
`endif
endmodule

// File: tb/tb_plb_access_scheduler.sv
// Randomized self-checking bench for plb_access_scheduler with a round-robin reference model.
module tb_plb_access_scheduler;
    localparam int LIB = 16;

    logic clk, rst;
    logic [31:0] stat_hits, stat_misses;
    int total, bad;

    plb_access_scheduler_if #(.ORAMU(32), .ORAML(20), .LeafWidth(32)) bus();

    plb_access_scheduler #(.ORAMU(32), .ORAML(20), .LeafWidth(32), .LeafInBlock(LIB), .StatWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .stat_hits_o(stat_hits), .stat_misses_o(stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  pcmd;
        logic [31:0] paddr;
        int          cmd_lat, hold_bad, din_cnt, din_bad, extra, early_bad, wait_bad, obr_bad, req_bad;
        logic [1:0]  rvld;
        logic        rhit, rev, obr, post;
        logic [19:0] rnew;
        logic [31:0] raddr;
        bit          timeout;
    } obs_t;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ReqValid = 0; bus.ReqCmd = 0; bus.ReqAddr = 0; bus.RespReady = 0;
        bus.RefillValid = 0; bus.RefillData = 0; bus.PLBCmdReady = 0; bus.PLBRefillDataReady = 0;
        bus.PLBValid = 0; bus.PLBHit = 0; bus.PLBUnInit = 0; bus.PLBEvict = 0;
        bus.PLBOldLeaf = 0; bus.PLBNewLeaf = 0; bus.PLBAddrOut = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Plays requesters, refill source and PLB unit for one command; records what the DUT did.
    task automatic run_txn(input logic [1:0] rv, input logic [3:0] cmds, input logic [63:0] addrs,
                           input int cmd_dly, input int resp_dly, input int rr_dly, input bit hit,
                           input bit tog, input logic [19:0] nl, input logic [31:0] ao, output obs_t o);
        int n, w, g;
        o = '{default: '0};
        bus.ReqValid = rv; bus.ReqCmd = cmds; bus.ReqAddr = addrs;
        bus.RefillValid = 1'b1; bus.RefillData = 32'hdead_beef; bus.PLBRefillDataReady = 1'b1;
        bus.RespReady = 0; bus.PLBCmdReady = 0; bus.PLBValid = 0;
        #1;
        n = 0;
        while (bus.ReqReady == 2'b00 && n < 10) begin cyc(); #1; n++; end
        if (bus.ReqReady == 2'b00) begin o.timeout = 1; return; end
        o.gnt = bus.ReqReady;
        g = bus.ReqReady[1] ? 1 : 0;
        if (bus.RefillReady || bus.PLBDInValid) o.extra++;
        n = 0;
        do begin
            cyc(); #1; n++;
            if (bus.RefillReady || bus.PLBDInValid) o.extra++;
            if (bus.ReqReady != 2'b00) o.req_bad++;
        end while (!bus.PLBCmdValid && n < 10);
        o.cmd_lat = n;
        if (!bus.PLBCmdValid) begin o.timeout = 1; return; end
        o.pcmd = bus.PLBCmd; o.paddr = bus.PLBAddr;
        for (int k = 0; k < cmd_dly; k++) begin
            cyc(); #1;
            if (!bus.PLBCmdValid || bus.PLBCmd !== o.pcmd || bus.PLBAddr !== o.paddr) o.hold_bad++;
            if (bus.ReqReady != 2'b00 || bus.RefillReady) o.req_bad++;
        end
        bus.PLBCmdReady = 1'b1;
        cyc();
        bus.PLBCmdReady = 1'b0;
        if (cmds[g*2 +: 2] == 2'b10) begin
            w = 0; n = 0;
            while (w < LIB && n < 400) begin
                bus.RefillValid = tog ? n[0] : 1'b1;
                bus.PLBRefillDataReady = ($urandom_range(0, 3) != 0);
                bus.RefillData = 32'ha5a5_0000 + w;
                #1;
                if (bus.PLBDInValid) begin
                    o.din_cnt++;
                    if (bus.PLBDIn !== bus.RefillData) o.din_bad++;
                end
                if (bus.PLBDInValid !== (bus.RefillValid && bus.PLBRefillDataReady)) o.din_bad++;
                if (bus.RefillValid && bus.RefillReady) w++;
                cyc(); n++;
            end
            if (w < LIB) begin o.timeout = 1; return; end
            bus.RefillValid = 1'b1; bus.PLBRefillDataReady = 1'b1; bus.RefillData = 32'h0bad_0017;
        end
        bus.RespReady = (g == 1) ? 2'b01 : 2'b10;
        for (int k = 0; k < resp_dly; k++) begin
            #1;
            if (bus.RespValid != 2'b00 || bus.PLBOutReady) o.early_bad++;
            if (bus.RefillReady || bus.PLBDInValid) o.extra++;
            if (bus.ReqReady != 2'b00) o.req_bad++;
            cyc();
        end
        bus.PLBValid = 1'b1; bus.PLBHit = hit; bus.PLBEvict = nl[0]; bus.PLBUnInit = nl[1];
        bus.PLBNewLeaf = nl; bus.PLBOldLeaf = ~nl; bus.PLBAddrOut = ao;
        for (int k = 0; k < rr_dly; k++) begin
            #1;
            if (bus.RespValid !== (2'b01 << g)) o.wait_bad++;
            if (bus.PLBOutReady) o.obr_bad++;
            if (bus.RefillReady || bus.PLBDInValid) o.extra++;
            if (bus.ReqReady != 2'b00) o.req_bad++;
            cyc();
        end
        bus.RespReady = 2'b11;
        #1;
        o.rvld = bus.RespValid; o.rhit = bus.RespHit; o.rev = bus.RespEvict;
        o.rnew = bus.RespNewLeaf; o.raddr = bus.RespAddr; o.obr = bus.PLBOutReady;
        cyc();
        bus.PLBValid = 0; bus.RespReady = 0; bus.ReqValid = 0; bus.RefillValid = 0;
        #1;
        o.post = (bus.RespValid != 2'b00) || bus.PLBOutReady || bus.PLBCmdValid || (bus.ReqReady != 2'b00);
    endtask

    task automatic test_reset();
        do_reset();
        bus.RefillValid = 1; bus.PLBRefillDataReady = 1; bus.PLBValid = 1; bus.RespReady = 2'b11;
        #1;
        total++; if (bus.ReqReady !== 2'b00) begin bad++; $display("FAIL reset_reqready got=%0b want=0", bus.ReqReady); end
        total++; if (bus.RespValid !== 2'b00) begin bad++; $display("FAIL reset_respvalid got=%0b want=0", bus.RespValid); end
        total++; if (bus.RefillReady !== 1'b0 || bus.PLBDInValid !== 1'b0) begin bad++; $display("FAIL reset_refill got=%0b%0b want=00", bus.RefillReady, bus.PLBDInValid); end
        total++; if (bus.PLBCmdValid !== 1'b0 || bus.PLBOutReady !== 1'b0) begin bad++; $display("FAIL reset_plb got=%0b%0b want=00", bus.PLBCmdValid, bus.PLBOutReady); end
        total++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_hits, stat_misses); end
        clear_inputs();
    endtask

    task automatic test_single_read();
        obs_t o;
        do_reset();
        run_txn(2'b01, 4'b0001, {32'h0, 32'h40}, 0, 2, 0, 1'b1, 1'b0, 20'h12345, 32'h40, o);
        total++; if (o.timeout) begin bad++; $display("FAIL single_timeout got=1 want=0"); end
        total++; if (o.gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%0b want=01", o.gnt); end
        total++; if (o.cmd_lat != 1) begin bad++; $display("FAIL single_latency got=%0d want=1", o.cmd_lat); end
        total++; if (o.pcmd !== 2'b01 || o.paddr !== 32'h40) begin bad++; $display("FAIL single_cmd got=%0b/%0h want=01/40", o.pcmd, o.paddr); end
        total++; if (o.rvld !== 2'b01 || o.rhit !== 1'b1) begin bad++; $display("FAIL single_resp got=%0b/%0b want=01/1", o.rvld, o.rhit); end
        total++; if (o.rnew !== 20'h12345 || o.obr !== 1'b1) begin bad++; $display("FAIL single_fields got=%0h/%0b want=12345/1", o.rnew, o.obr); end
        total++; if (o.early_bad != 0 || o.extra != 0 || o.post) begin bad++; $display("FAIL single_protocol got=%0d/%0d/%0b want=0/0/0", o.early_bad, o.extra, o.post); end
    endtask

    task automatic test_round_robin();
        obs_t o;
        logic [1:0] want, prev;
        do_reset();
        prev = 2'b00;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            run_txn(2'b11, 4'b0101, {32'h2000 + i, 32'h1000 + i}, i, 1, 0, 1'b0, 1'b0, 20'h00abc, 32'h7, o);
            total++; if (o.gnt !== want) begin bad++; $display("FAIL rr_gnt%0d got=%0b want=%0b", i, o.gnt, want); end
            total++; if (o.paddr !== ((want == 2'b01) ? 32'h1000 + i : 32'h2000 + i)) begin bad++; $display("FAIL rr_addr%0d got=%0h", i, o.paddr); end
            total++; if (o.gnt === prev || o.rvld !== want) begin bad++; $display("FAIL rr_route%0d got=%0b/%0b want=%0b", i, o.gnt, o.rvld, want); end
            total++; if (o.hold_bad != 0 || o.req_bad != 0) begin bad++; $display("FAIL rr_hold%0d got=%0d/%0d want=0/0", i, o.hold_bad, o.req_bad); end
            prev = o.gnt;
        end
    endtask

    task automatic test_refill();
        obs_t o;
        do_reset();
        run_txn(2'b10, 4'b1000, {32'h100, 32'h0}, 1, 3, 0, 1'b1, 1'b1, 20'h0f0f0, 32'h100, o);
        total++; if (o.timeout) begin bad++; $display("FAIL refill_timeout got=1 want=0"); end
        total++; if (o.pcmd !== 2'b10 || o.paddr !== 32'h100) begin bad++; $display("FAIL refill_cmd got=%0b/%0h want=10/100", o.pcmd, o.paddr); end
        total++; if (o.din_cnt != LIB) begin bad++; $display("FAIL refill_pulses got=%0d want=%0d", o.din_cnt, LIB); end
        total++; if (o.din_bad != 0) begin bad++; $display("FAIL refill_data got=%0d want=0", o.din_bad); end
        total++; if (o.extra != 0 || o.early_bad != 0) begin bad++; $display("FAIL refill_word17 got=%0d/%0d want=0/0", o.extra, o.early_bad); end
        total++; if (o.rvld !== 2'b10) begin bad++; $display("FAIL refill_route got=%0b want=10", o.rvld); end
    endtask

    task automatic test_init_refill();
        obs_t o;
        do_reset();
        run_txn(2'b10, 4'b1100, {32'h200, 32'h0}, 0, 4, 1, 1'b0, 1'b0, 20'h00001, 32'h200, o);
        total++; if (o.pcmd !== 2'b11 || o.paddr !== 32'h200) begin bad++; $display("FAIL init_cmd got=%0b/%0h want=11/200", o.pcmd, o.paddr); end
        total++; if (o.din_cnt != 0 || o.extra != 0) begin bad++; $display("FAIL init_norefill got=%0d/%0d want=0/0", o.din_cnt, o.extra); end
        total++; if (o.rvld !== 2'b10 || o.wait_bad != 0) begin bad++; $display("FAIL init_route got=%0b/%0d want=10/0", o.rvld, o.wait_bad); end
    endtask

    task automatic test_resp_backpressure();
        obs_t o;
        do_reset();
        run_txn(2'b01, 4'b0001, {32'h0, 32'h80}, 0, 1, 10, 1'b0, 1'b0, 20'h55555, 32'h80, o);
        total++; if (o.obr_bad != 0) begin bad++; $display("FAIL bp_outready got=%0d want=0", o.obr_bad); end
        total++; if (o.wait_bad != 0) begin bad++; $display("FAIL bp_respvalid got=%0d want=0", o.wait_bad); end
        total++; if (o.req_bad != 0) begin bad++; $display("FAIL bp_noreq got=%0d want=0", o.req_bad); end
        total++; if (o.obr !== 1'b1 || o.rvld !== 2'b01 || o.post) begin bad++; $display("FAIL bp_release got=%0b/%0b/%0b want=1/01/0", o.obr, o.rvld, o.post); end
    endtask

    task automatic test_reset_mid_refill();
        int leaks;
        do_reset();
        bus.ReqValid = 2'b10; bus.ReqCmd = 4'b1000; bus.ReqAddr = {32'h100, 32'h0};
        cyc();
        bus.ReqValid = 2'b00; bus.PLBCmdReady = 1'b1;
        cyc();
        bus.PLBCmdReady = 1'b0; bus.RefillValid = 1'b1; bus.PLBRefillDataReady = 1'b1;
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.PLBValid = 1'b1; bus.RespReady = 2'b11;
        #1;
        total++; if (bus.RefillReady !== 1'b0 || bus.PLBDInValid !== 1'b0) begin bad++; $display("FAIL rstmid_refill got=%0b%0b want=00", bus.RefillReady, bus.PLBDInValid); end
        total++; if (bus.RespValid !== 2'b00 || bus.PLBOutReady !== 1'b0) begin bad++; $display("FAIL rstmid_resp got=%0b/%0b want=0/0", bus.RespValid, bus.PLBOutReady); end
        total++; if (bus.PLBCmdValid !== 1'b0 || bus.ReqReady !== 2'b00) begin bad++; $display("FAIL rstmid_cmd got=%0b/%0b want=0/0", bus.PLBCmdValid, bus.ReqReady); end
        leaks = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            if (bus.RespValid != 2'b00 || bus.PLBOutReady || bus.RefillReady) leaks++;
        end
        total++; if (leaks != 0) begin bad++; $display("FAIL rstmid_noresp got=%0d want=0", leaks); end
        clear_inputs();
    endtask

    task automatic test_stats();
        obs_t o;
        logic [31:0] wh, wm;
        do_reset();
        for (int i = 0; i < 3; i++)
            run_txn(2'b01, 4'b0001, {32'h0, 32'h300 + i}, 0, 1, 0, 1'b1, 1'b0, 20'h1, 32'h1, o);
        run_txn(2'b01, 4'b0000, {32'h0, 32'h400}, 0, 1, 0, 1'b0, 1'b0, 20'h2, 32'h2, o);
        run_txn(2'b10, 4'b1100, {32'h500, 32'h0}, 0, 1, 0, 1'b1, 1'b0, 20'h3, 32'h3, o);
`ifdef PLB_STATS_EN
        wh = 32'd3; wm = 32'd1;
`else
        wh = 32'd0; wm = 32'd0;
`endif
        total++; if (stat_hits !== wh) begin bad++; $display("FAIL stats_hits got=%0d want=%0d", stat_hits, wh); end
        total++; if (stat_misses !== wm) begin bad++; $display("FAIL stats_misses got=%0d want=%0d", stat_misses, wm); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [1:0] pend, want;
        logic [1:0] pc [2];
        logic [31:0] pa [2];
        logic [19:0] nl;
        logic [31:0] ao;
        bit hit;
        int last, g, prot;
        do_reset();
        last = 1;
        pend = 2'b00;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    pc[r] = 2'($urandom_range(0, 3));
                    pa[r] = $urandom;
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1; pc[0] = 2'b01; pa[0] = $urandom;
            end
            g = (pend == 2'b11) ? (1 - last) : (pend[1] ? 1 : 0);
            want = 2'b01 << g;
            hit = $urandom_range(0, 1) == 1;
            nl = 20'($urandom);
            ao = $urandom;
            run_txn(pend, {pc[1], pc[0]}, {pa[1], pa[0]}, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), hit, $urandom_range(0, 1) == 1, nl, ao, o);
            total++; if (o.timeout) begin bad++; $display("FAIL rnd_timeout%0d got=1 want=0", it); end
            total++; if (o.gnt !== want) begin bad++; $display("FAIL rnd_gnt%0d got=%0b want=%0b", it, o.gnt, want); end
            total++; if (o.pcmd !== pc[g] || o.paddr !== pa[g]) begin bad++; $display("FAIL rnd_cmd%0d got=%0b/%0h want=%0b/%0h", it, o.pcmd, o.paddr, pc[g], pa[g]); end
            total++; if (o.din_cnt != ((pc[g] == 2'b10) ? LIB : 0)) begin bad++; $display("FAIL rnd_refill%0d got=%0d", it, o.din_cnt); end
            total++; if (o.rvld !== want || o.rhit !== hit || o.rev !== nl[0]) begin bad++; $display("FAIL rnd_resp%0d got=%0b/%0b/%0b want=%0b/%0b/%0b", it, o.rvld, o.rhit, o.rev, want, hit, nl[0]); end
            total++; if (o.rnew !== nl || o.raddr !== ao) begin bad++; $display("FAIL rnd_fields%0d got=%0h/%0h want=%0h/%0h", it, o.rnew, o.raddr, nl, ao); end
            prot = o.hold_bad + o.din_bad + o.extra + o.early_bad + o.wait_bad + o.obr_bad + o.req_bad + int'(o.post);
            total++; if (prot != 0 || o.cmd_lat != 1) begin bad++; $display("FAIL rnd_protocol%0d got=%0d/%0d want=0/1", it, prot, o.cmd_lat); end
            pend[g] = 1'b0;
            last = g;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_refill();
        test_init_refill();
        test_resp_backpressure();
        test_reset_mid_refill();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
